// File: rtl/sensor_setpoint_gen.sv
// sensor_setpoint_gen: three raw buttons to a debounced, auto-repeating 7-bit temperature setpoint and a humidity toggle.
// Define TABLE_STEP_EN to step through a fixed table of legal codes instead of +/-1.
module sensor_setpoint_gen #(
  parameter int DEB_CYCLES   = 16,
  parameter int REPEAT_DELAY = 64,
  parameter int REPEAT_RATE  = 8,
  parameter int TMIN         = 0,
  parameter int TMAX         = 60,
  parameter int RESET_VAL    = 20
) (
  input  logic       clock,
  input  logic       clr,
  input  logic       btn_up,
  input  logic       btn_dn,
  input  logic       btn_hu,
  output logic [6:0] inp,
  output logic       hu,
  output logic       upd
);
  localparam int DW = $clog2(DEB_CYCLES);
  localparam int RMAX = REPEAT_DELAY > REPEAT_RATE ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW = $clog2(RMAX + 1);
  typedef enum logic [2:0] {IDLE, HOLD_UP, HOLD_DN, RPT_UP, RPT_DN} state_t;
  state_t r_state, w_nstate;
  logic [2:0] r_s1, r_s2, r_deb, r_prev, w_rise;
  logic [DW-1:0] r_dc [3];
  logic [RW-1:0] r_cnt, w_ncnt;
  logic [6:0] r_inp, w_next;
  logic r_hu, r_upd, w_inc, w_dec, w_go, w_upside;
  // bit 0 = up, bit 1 = dn, bit 2 = hu
  always_ff @(posedge clock or posedge clr)
    if (clr) begin
      r_s1 <= '0;
      r_s2 <= '0;
      r_deb <= '0;
      r_prev <= '0;
      for (int k = 0; k < 3; k++) r_dc[k] <= '0;
    end else begin
      r_s1 <= {btn_hu, btn_dn, btn_up};
      r_s2 <= r_s1;
      r_prev <= r_deb;
      for (int k = 0; k < 3; k++)
        if (r_s2[k] == r_deb[k]) r_dc[k] <= '0;
        else if (r_dc[k] == DW'(DEB_CYCLES - 1)) begin
          r_dc[k] <= '0;
          r_deb[k] <= ~r_deb[k];
        end else r_dc[k] <= r_dc[k] + DW'(1);
    end
  assign w_rise = r_deb & ~r_prev;
  assign w_upside = r_state == HOLD_UP || r_state == RPT_UP;
  always_comb begin
    w_nstate = r_state;
    w_ncnt = r_cnt;
    w_inc = 1'b0;
    w_dec = 1'b0;
    if (r_deb[0] && r_deb[1]) begin
      w_nstate = IDLE;
      w_ncnt = '0;
    end else
      case (r_state)
        IDLE:
          if (w_rise[0] || w_rise[1]) begin
            w_inc = w_rise[0];
            w_dec = !w_rise[0];
            w_nstate = w_rise[0] ? HOLD_UP : HOLD_DN;
            w_ncnt = RW'(REPEAT_DELAY - 1);
          end
        default:
          if (!(w_upside ? r_deb[0] : r_deb[1])) w_nstate = IDLE;
          else if (r_cnt == '0) begin
            w_inc = w_upside;
            w_dec = !w_upside;
            w_nstate = w_upside ? RPT_UP : RPT_DN;
            w_ncnt = RW'(REPEAT_RATE - 1);
          end else w_ncnt = r_cnt - RW'(1);
      endcase
  end
`ifdef TABLE_STEP_EN
  localparam logic [6:0] INIT = 7'd20;
  localparam logic [6:0] TAB [16] = '{7'd10, 7'd15, 7'd20, 7'd25, 7'd27, 7'd30, 7'd32, 7'd35,
                                      7'd39, 7'd41, 7'd60, 7'd60, 7'd60, 7'd60, 7'd60, 7'd60};
  logic [3:0] r_idx, w_nidx;
  assign w_go = (w_inc && r_idx != 4'd10) || (w_dec && r_idx != 4'd0);
  assign w_nidx = w_inc ? r_idx + 4'd1 : r_idx - 4'd1;
  assign w_next = TAB[w_nidx];
  always_ff @(posedge clock or posedge clr)
    if (clr) r_idx <= 4'd2;
    else if (w_go) r_idx <= w_nidx;
`else
  localparam logic [6:0] INIT = 7'(RESET_VAL);
  assign w_go = (w_inc && r_inp < 7'(TMAX)) || (w_dec && r_inp > 7'(TMIN));
  assign w_next = w_inc ? r_inp + 7'd1 : r_inp - 7'd1;
`endif
  always_ff @(posedge clock or posedge clr)
    if (clr) begin
      r_state <= IDLE;
      r_cnt <= '0;
      r_inp <= INIT;
      r_upd <= 1'b0;
      r_hu <= 1'b0;
    end else begin
      r_state <= w_nstate;
      r_cnt <= w_ncnt;
      r_upd <= w_go;
      if (w_go) r_inp <= w_next;
      if (w_rise[2]) r_hu <= ~r_hu;
    end
  assign inp = r_inp;
  assign hu = r_hu;
  assign upd = r_upd;
endmodule
